// File: rtl/stb_gen_pkg.sv
// Shared types for the averaging strobe generator: FSM state encoding and accumulator sizing.
// No logic and no timing of its own.
package stb_gen_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      MEASURE,
      CALC,
      RUN
   } stb_gen_avg_state_t;

   // The sum of 2^avg_log2 intervals, each below 2^cnt_w, needs avg_log2 extra bits.
   function automatic int unsigned acc_width(input int unsigned cnt_w, input int unsigned avg_log2);
      return cnt_w + avg_log2;
   endfunction

endpackage

// File: rtl/stb_phase_gen.sv
// Phase counter plus a registered strobe window. int_stb is high for hold_i of every period_i cycles.
// It lags the phase by 1 cycle. There is no backpressure; the block free-runs while lock_i is high.
module stb_phase_gen #(
   parameter int unsigned W = 32
) (
   input  logic         clk_i,
   input  logic         arst_ni,
   input  logic         clr_i,
   input  logic         cnt_i,
   input  logic         lock_i,
   input  logic [W-1:0] period_i,
   input  logic [W-1:0] hold_i,
   input  logic [W-1:0] delay_i,
   output logic         stb_o
);

   logic [W-1:0] ph_q, ph_d, off;
   logic         stb_q, stb_d;

   always_comb begin
      ph_d = ph_q;
      if (clr_i) begin
         ph_d = '0;
      end else if (cnt_i) begin
         // Before lock the period is not yet valid, so the count runs on without wrapping.
         ph_d = (lock_i && (ph_q >= period_i - W'(1))) ? '0 : ph_q + W'(1);
      end
      off   = (ph_q >= delay_i) ? ph_q - delay_i : ph_q + (period_i - delay_i);
      stb_d = lock_i && !clr_i && (off < hold_i);
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         ph_q  <= '0;
         stb_q <= 1'b0;
      end else begin
         ph_q  <= ph_d;
         stb_q <= stb_d;
      end
   end

   assign stb_o = stb_q;

endmodule

// File: rtl/sync_ff.sv
// Multi-stage synchroniser for one asynchronous bit.
// Latency is STAGES cycles. There is no handshake and no backpressure.
module sync_ff #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk_i,
   input  logic arst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) sync_q <= '0;
      else          sync_q <= (sync_q << 1) | STAGES'(d_i);
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/stb_gen_avg.sv
// Measures the period of sig_i, averaged over 2^AVG_LOG2 intervals, then emits a phase-locked, programmable strobe.
// Lock comes 1 CALC cycle after the last averaged edge. There is no backpressure; oe_i gates stb_o combinationally.
module stb_gen_avg
   import stb_gen_pkg::*;
#(
   parameter int unsigned T_CNT_WIDTH    = 32,
   parameter int unsigned AVG_LOG2       = 2,
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
   input  logic                   clk_i,
   input  logic                   arst_ni,
   input  logic                   sig_i,
   input  logic                   run_det_i,
   input  logic                   oe_i,
   input  logic [T_CNT_WIDTH-1:0] hold_i,
   input  logic [T_CNT_WIDTH-1:0] delay_i,
   output logic                   err_o,
   output logic                   rdy_o,
   output logic                   lock_o,
   output logic                   stb_o,
   output logic [T_CNT_WIDTH-1:0] stb_period_o
);

   localparam int unsigned            ACC_W     = acc_width(T_CNT_WIDTH, AVG_LOG2);
   localparam int unsigned            EC_W      = AVG_LOG2 + 1;
   localparam logic [EC_W-1:0]        LAST_EDGE = EC_W'((1 << AVG_LOG2) - 1);
   localparam logic [T_CNT_WIDTH-1:0] TO_LAST   = T_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   logic sig_s, run_s, sig_dly_q, run_dly_q, sig_rise, run_rise;

   sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sig (.clk_i(clk_i), .arst_ni(arst_ni), .d_i(sig_i),     .q_o(sig_s));
   sync_ff #(.STAGES(SYNC_STAGES)) u_sync_run (.clk_i(clk_i), .arst_ni(arst_ni), .d_i(run_det_i), .q_o(run_s));

   assign sig_rise = sig_s & ~sig_dly_q;
   assign run_rise = run_s & ~run_dly_q;

   stb_gen_avg_state_t     state_q, state_d;
   logic                   err_q, err_d;
   logic [T_CNT_WIDTH-1:0] period_q, period_d, int_cnt_q, int_cnt_d;
   logic [T_CNT_WIDTH-1:0] hold_q, hold_d, delay_q, delay_d, period_calc;
   logic [ACC_W-1:0]       acc_q, acc_d;
   logic [EC_W-1:0]        edge_cnt_q, edge_cnt_d;
   logic                   cfg_bad, ph_clr, ph_cnt, int_stb;

   assign period_calc = T_CNT_WIDTH'(acc_q >> AVG_LOG2);
   assign cfg_bad     = (period_calc == '0) || (hold_i == '0) ||
                        (hold_i >= period_calc) || (delay_i >= period_calc);

   always_comb begin
      state_d    = state_q;
      err_d      = err_q;
      period_d   = period_q;
      int_cnt_d  = int_cnt_q;
      acc_d      = acc_q;
      edge_cnt_d = edge_cnt_q;
      hold_d     = hold_q;
      delay_d    = delay_q;
      ph_clr     = 1'b0;
      if (run_rise) begin
         state_d   = ARM;
         err_d     = 1'b0;
         int_cnt_d = '0;
         ph_clr    = 1'b1;
      end else begin
         case (state_q)
            ARM: begin
               if (sig_rise) begin
                  int_cnt_d  = '0;
                  acc_d      = '0;
                  edge_cnt_d = '0;
                  state_d    = MEASURE;
               end else if (int_cnt_q == TO_LAST) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  int_cnt_d = int_cnt_q + T_CNT_WIDTH'(1);
               end
            end
            MEASURE: begin
               if (sig_rise) begin
                  acc_d      = acc_q + ACC_W'(int_cnt_q) + ACC_W'(1);
                  int_cnt_d  = '0;
                  edge_cnt_d = edge_cnt_q + EC_W'(1);
                  if (edge_cnt_q == LAST_EDGE) begin
                     state_d = CALC;
                     ph_clr  = 1'b1;
                  end
               end else if (int_cnt_q == TO_LAST) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  int_cnt_d = int_cnt_q + T_CNT_WIDTH'(1);
               end
            end
            CALC: begin
               period_d = period_calc;
               hold_d   = hold_i;
               delay_d  = delay_i;
               if (cfg_bad) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = RUN;
               end
            end
            IDLE, RUN: ;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_q    <= IDLE;
         err_q      <= 1'b0;
         period_q   <= '0;
         int_cnt_q  <= '0;
         acc_q      <= '0;
         edge_cnt_q <= '0;
         hold_q     <= '0;
         delay_q    <= '0;
         sig_dly_q  <= 1'b0;
         run_dly_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         err_q      <= err_d;
         period_q   <= period_d;
         int_cnt_q  <= int_cnt_d;
         acc_q      <= acc_d;
         edge_cnt_q <= edge_cnt_d;
         hold_q     <= hold_d;
         delay_q    <= delay_d;
         sig_dly_q  <= sig_s;
         run_dly_q  <= run_s;
      end
   end

   assign ph_cnt = (state_q == CALC) || (state_q == RUN);

   stb_phase_gen #(.W(T_CNT_WIDTH)) u_phase (
      .clk_i    (clk_i),
      .arst_ni  (arst_ni),
      .clr_i    (ph_clr),
      .cnt_i    (ph_cnt),
      .lock_i   (lock_o),
      .period_i (period_q),
      .hold_i   (hold_q),
      .delay_i  (delay_q),
      .stb_o    (int_stb)
   );

   assign rdy_o        = (state_q == IDLE);
   assign lock_o       = (state_q == RUN);
   assign err_o        = err_q;
   assign stb_period_o = period_q;
   assign stb_o        = int_stb & oe_i & lock_o & ~err_q;

endmodule

// File: tb/tb_stb_gen_avg.sv
// Directed bench for stb_gen_avg. Expected measurement outcomes are queued at each start and popped when the DUT locks or errors.
module tb_stb_gen_avg;

   localparam int W  = 32;
   localparam int TO = 1000;

   logic          clk_i = 1'b0;
   logic          arst_ni, sig_i, run_det_i, oe_i;
   logic [W-1:0]  hold_i, delay_i;
   logic          err_o, rdy_o, lock_o, stb_o;
   logic [W-1:0]  stb_period_o;

   always #5 clk_i = ~clk_i;

   stb_gen_avg #(
      .T_CNT_WIDTH(W), .AVG_LOG2(2), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_i(clk_i), .arst_ni(arst_ni), .sig_i(sig_i), .run_det_i(run_det_i), .oe_i(oe_i),
      .hold_i(hold_i), .delay_i(delay_i), .err_o(err_o), .rdy_o(rdy_o), .lock_o(lock_o),
      .stb_o(stb_o), .stb_period_o(stb_period_o)
   );

   int          n_checks = 0;
   int          n_fails  = 0;
   int unsigned cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   // sig_i generator: repeating 4-interval pattern, or single pulses on request when disabled
   int          iv[4];
   bit          gen_en = 1'b0;
   bit          shot_req = 1'b0;
   int unsigned last_sig_cyc = 0;

   initial begin
      sig_i = 1'b0;
      forever begin
         if (!gen_en) begin
            @(negedge clk_i);
            if (shot_req) begin
               shot_req = 1'b0;
               sig_i = 1'b1;
               repeat (5) @(negedge clk_i);
            end
            sig_i = 1'b0;
         end else begin
            for (int k = 0; k < 4; k++) begin
               if (!gen_en) break;
               @(negedge clk_i);
               sig_i = 1'b1;
               last_sig_cyc = cyc;
               repeat (5) @(negedge clk_i);
               sig_i = 1'b0;
               repeat (iv[k] - 6) @(negedge clk_i);
            end
         end
      end
   end

   typedef struct {
      logic [W-1:0] per;
      logic         err;
   } exp_t;
   exp_t sb[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_iv(input int a, input int b, input int c, input int d);
      iv[0] = a; iv[1] = b; iv[2] = c; iv[3] = d;
   endtask

   task automatic start_meas(input logic [W-1:0] per, input logic err);
      exp_t e;
      e.per = per;
      e.err = err;
      sb.push_back(e);
      @(negedge clk_i);
      run_det_i = 1'b1;
      repeat (4) @(negedge clk_i);
      run_det_i = 1'b0;
   endtask

   task automatic wait_result(input string tag);
      exp_t e;
      int   t;
      bit   done;
      done = 1'b0;
      for (t = 0; t < 50 && !done; t++) begin
         step();
         done = !lock_o && !err_o && !rdy_o;
      end
      check({tag, "_enter_measure"}, done, 1);
      done = 1'b0;
      for (t = 0; t < 3000 && !done; t++) begin
         step();
         done = lock_o || err_o;
      end
      check({tag, "_done"}, done, 1);
      e = sb.pop_front();
      check({tag, "_err"}, err_o, e.err);
      check({tag, "_lock"}, lock_o, !e.err);
      check({tag, "_period"}, stb_period_o, e.per);
   endtask

   // Samples stb_o for n cycles: highs in the first 200, first/second rising edge and phase from the last sig_i rise.
   task automatic observe(input int n, output int highs, output int spacing, output int off);
      logic prev;
      int   rises, r1;
      highs = 0; rises = 0; r1 = 0; spacing = 0; off = -1;
      step();
      prev = stb_o;
      for (int i = 0; i < n; i++) begin
         step();
         if (stb_o && i < 200) highs++;
         if (stb_o && !prev) begin
            rises++;
            if (rises == 1) begin
               r1  = int'(cyc);
               off = int'(cyc - last_sig_cyc);
            end else if (rises == 2) begin
               spacing = int'(cyc) - r1;
            end
         end
         prev = stb_o;
      end
   endtask

   int highs, spacing, off0, off3, off_tmp;
   bit seen;

   initial begin
      arst_ni = 1'b1; run_det_i = 1'b0; oe_i = 1'b1; hold_i = 10; delay_i = 0;
      set_iv(100, 100, 100, 100);
      #2 arst_ni = 1'b0;
      #20;
      check("rst_rdy", rdy_o, 1);
      check("rst_lock", lock_o, 0);
      check("rst_stb", stb_o, 0);
      check("rst_err", err_o, 0);
      check("rst_period", stb_period_o, 0);
      @(negedge clk_i);
      arst_ni = 1'b1;

      // Steady 100-cycle period, hold 10, delay 0
      gen_en = 1'b1;
      repeat (50) step();
      start_meas(100, 0);
      wait_result("run1");
      repeat (150) step();
      observe(250, highs, spacing, off0);
      check("run1_highs", highs, 20);
      check("run1_spacing", spacing, 100);

      // Jittered intervals average to 100
      set_iv(99, 101, 98, 102);
      repeat (150) step();
      start_meas(100, 0);
      wait_result("jitter");

      // 403/4 truncates to 100
      set_iv(100, 100, 100, 103);
      repeat (150) step();
      start_meas(100, 0);
      wait_result("trunc");

      // delay 30, hold 20: same spacing, phase shifted by 30
      set_iv(100, 100, 100, 100);
      hold_i = 20; delay_i = 30;
      repeat (150) step();
      start_meas(100, 0);
      wait_result("delay30");
      repeat (150) step();
      observe(250, highs, spacing, off3);
      check("delay30_highs", highs, 40);
      check("delay30_spacing", spacing, 100);
      check("delay30_shift", off3 - off0, 30);

      // Inputs changed during RUN have no effect
      hold_i = 5; delay_i = 0;
      observe(250, highs, spacing, off_tmp);
      check("run_cfg_ignored_highs", highs, 40);
      check("run_cfg_ignored_phase", off_tmp, off3);

      // hold equal to period is illegal
      hold_i = 100;
      start_meas(100, 1);
      wait_result("cfg_err");
      check("cfg_err_rdy", rdy_o, 1);
      observe(200, highs, spacing, off_tmp);
      check("cfg_err_stb_quiet", highs, 0);
      hold_i = 10;
      start_meas(100, 0);
      step();
      check("err_cleared", err_o, 0);
      wait_result("relock");

      // Input stalled: timeout with no edges, then with a single edge
      gen_en = 1'b0;
      repeat (300) step();
      start_meas(100, 1);
      repeat (TO - 100) step();
      check("timeout_not_early", err_o, 0);
      wait_result("timeout0");
      start_meas(100, 1);
      repeat (20) step();
      shot_req = 1'b1;
      wait_result("timeout1");

      // Output enable gates immediately
      gen_en = 1'b1;
      repeat (50) step();
      start_meas(100, 0);
      wait_result("run6");
      seen = 1'b0;
      for (int i = 0; i < 250 && !seen; i++) begin
         step();
         seen = stb_o;
      end
      check("oe_stb_seen", seen, 1);
      oe_i = 1'b0;
      #1;
      check("oe_gate_now", stb_o, 0);
      observe(200, highs, spacing, off_tmp);
      check("oe_gate_highs", highs, 0);
      oe_i = 1'b1;

      // Restart mid-RUN onto a 50-cycle period
      set_iv(50, 50, 50, 50);
      repeat (150) step();
      start_meas(50, 0);
      step();
      check("restart_lock_drop", lock_o, 0);
      wait_result("period50");

      // Asynchronous reset mid-RUN
      repeat (100) step();
      #2;
      arst_ni = 1'b0;
      #1;
      check("arst_rdy", rdy_o, 1);
      check("arst_lock", lock_o, 0);
      check("arst_stb", stb_o, 0);
      check("arst_err", err_o, 0);
      check("arst_period", stb_period_o, 0);
      @(negedge clk_i);
      arst_ni = 1'b1;
      repeat (5) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
